sobol_point_sequencer: RTL and testbench
========================================

// Module: sobol_point_sequencer
// PURPOSE
//  Initiator for the sobol generator's idx/dim handshake. On start it issues (idx, dim) requests in
//  point-major order: base_idx..base_idx+num_points-1, dims 0..num_dims-1.
//  It collects the in-order sobol_out responses and packs each point's dims into one coordinate vector.
//  That vector is handed downstream to the path/LSM pipeline.
// PARAMETERS
//  WIDTH            32  sobol word / index width
//  M                50  max dimensions (matches sobol M)
//  CNT_W            16  width of num_points
//  MAX_OUTSTANDING  4   max requests accepted by sobol but not yet returned (>=1)
// PORTS
//  clk         in   1             clock, all logic on rising edge
//  rst         in   1             asynchronous, active-high reset
//  start       in   1             one-cycle pulse; latches config when idle
//  base_idx    in   WIDTH         first sequence index
//  num_points  in   CNT_W         points to generate
//  num_dims    in   $clog2(M+1)   dims per point, 1..M
//  busy        out  1             run in progress
//  done        out  1             one-cycle pulse at end of run
//  req_valid   out  1             to sobol valid_in
//  req_ready   in   1             from sobol ready_out
//  req_idx     out  WIDTH         to sobol idx_in
//  req_dim     out  $clog2(M)     to sobol dim_in
//  rsp_valid   in   1             from sobol valid_out
//  rsp_ready   out  1             to sobol ready_in
//  rsp_data    in   WIDTH         from sobol sobol_out
//  pt_valid    out  1             packed point available
//  pt_ready    in   1             downstream accept
//  pt_index    out  CNT_W         point ordinal within run, 0-based
//  pt_coords   out  M*WIDTH       dim d at [d*WIDTH +: WIDTH]; slots >= num_dims are 0
// BEHAVIOUR
//  - Reset: state IDLE. busy, done, req_valid, rsp_ready and pt_valid are 0.
//    req_idx, req_dim, pt_index and pt_coords are 0. All counters are 0.
//  - FSM IDLE -> RUN on start. Config is latched. start during RUN/DRAIN is ignored.
//  - num_points==0, or num_dims outside 1..M: IDLE -> DONE directly, with no requests and no points.
//  - RUN: req_valid=1 while outstanding<MAX_OUTSTANDING. Transfer on req_valid&req_ready.
//    After each transfer, req_dim increments; at num_dims-1 it wraps to 0 and req_idx increments.
//    After the last (point, dim) transfer the FSM goes to DRAIN.
//  - req_idx/req_dim are held stable while req_valid=1 and req_ready=0.
//  - DRAIN: no requests issued. -> DONE when outstanding==0, no partial point is held, and pt_valid=0.
//  - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RUN and DRAIN only.
//  - outstanding counts +1 on a request transfer and -1 on a response transfer.
//    A request and response transfer in the same cycle leave it unchanged.
//  - Collector: rsp_ready = !(pt_valid & !pt_ready). A response writes the slot at the collector dim counter.
//    The response that completes dim num_dims-1 sets pt_valid on the next cycle and clears the counter.
//    pt_index increments per emitted point.
//  - pt_valid/pt_coords/pt_index are held until pt_ready.
//    A point may be accepted in the same cycle the next point's dim-0 response arrives.
//  - Index arithmetic wraps modulo 2^WIDTH. WIDTH'hFFFFFFFF followed by 0 is legal.
//  - Async reset mid-run aborts immediately. Nothing is re-issued.
//    The sobol block shares the same reset, so no stale responses are expected.
// CONFIGURATION
//  - SOBOL_SEQ_SKIP_ZERO_EN defined: if the latched base_idx==0, issuing starts at idx 1.
//    Exactly num_points points are still produced, covering idx 1..num_points. This drops the all-zero point.
//  - Not defined: issuing starts at base_idx exactly as given.
// STRUCTURE
//  - Package sobol_pkg: WIDTH/M defaults, the seq_state_e enum (IDLE, RUN, DRAIN, DONE),
//    and the dim-width localparams $clog2(M) and $clog2(M+1).
//  - One sub-module, sobol_point_packer: the collector dim counter, coordinate register and pt_* handshake.
//    The top level holds the FSM, issue counters and the outstanding counter.
// TESTING
//  - base=0, points=2, dims=2, sobol always ready
//    -> requests (0,0)(0,1)(1,0)(1,1); points {0,0}, then {80000000,80000000}; done pulses once.
//  - req_ready=0 for 3 cycles mid-run -> req_idx/req_dim stable; no request lost or duplicated.
//  - pt_ready=0 for 5 cycles -> pt_coords stable; rsp_ready=0.
//    Outstanding count never exceeds MAX_OUTSTANDING; final point count is correct.
//  - base=32'hFFFFFFFF, points=2, dims=1 -> req_idx 0xFFFFFFFF, then 0x00000000.
//  - points=0 -> done pulse one cycle after start; req_valid never asserted.
//  - Assert rst during DRAIN -> all outputs 0 next edge.
//    A new start then runs cleanly, with pt_index restarting at 0.
//  - With SOBOL_SEQ_SKIP_ZERO_EN, base=0, points=2, dims=1 -> req_idx 1, 2; first coord 80000000.

Source files
------------

// File: rtl/sobol_pkg.sv
// Shared definitions for the Sobol point sequencer: default sizes, dim-index widths and run states.
package sobol_pkg;

   localparam int SOBOL_WIDTH  = 32;
   localparam int SOBOL_M      = 50;
   localparam int SOBOL_DIM_W  = $clog2(SOBOL_M);
   localparam int SOBOL_NDIM_W = $clog2(SOBOL_M + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } seq_state_e;

endpackage

// File: rtl/sobol_point_packer.sv
// Collects in-order sobol responses into one coordinate vector per point and offers it downstream.
module sobol_point_packer
   import sobol_pkg::*;
#(
   parameter int WIDTH = SOBOL_WIDTH,
   parameter int M     = SOBOL_M,
   parameter int CNT_W = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      active,
   input  logic [$clog2(M+1)-1:0]    num_dims,
   input  logic                      rsp_valid,
   output logic                      rsp_ready,
   input  logic [WIDTH-1:0]          rsp_data,
   output logic                      pt_valid,
   input  logic                      pt_ready,
   output logic [CNT_W-1:0]          pt_index,
   output logic [M*WIDTH-1:0]        pt_coords,
   output logic                      partial
);

   localparam int DIM_W  = $clog2(M);
   localparam int NDIM_W = $clog2(M + 1);

   logic [DIM_W-1:0]   col_dim_q, col_dim_d;
   logic [M*WIDTH-1:0] coords_q, coords_d;
   logic               pt_valid_q, pt_valid_d;
   logic [CNT_W-1:0]   pt_index_q, pt_index_d;
   logic               rsp_fire;
   logic               last_dim;

   // One coordinate register suffices: a response is only taken when the held point is gone
   // or is being accepted in the same cycle.
   assign rsp_ready = active & ~(pt_valid_q & ~pt_ready);
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign last_dim  = (NDIM_W'(col_dim_q) == num_dims - NDIM_W'(1));

   always_comb begin
      // NOTE: every signal gets its default first so no path leaves it unassigned and a latch is never inferred.
      col_dim_d  = col_dim_q;
      coords_d   = coords_q;
      pt_valid_d = pt_valid_q & ~pt_ready;
      pt_index_d = pt_index_q;
      if (pt_valid_q & pt_ready) pt_index_d = pt_index_q + CNT_W'(1);
      if (rsp_fire) begin
         coords_d[int'(col_dim_q)*WIDTH +: WIDTH] = rsp_data;
         if (last_dim) begin
            col_dim_d  = '0;
            pt_valid_d = 1'b1;
         end else begin
            col_dim_d  = col_dim_q + DIM_W'(1);
         end
      end
      // Clearing at run start keeps slots above num_dims at zero for the whole run.
      if (clear) begin
         col_dim_d  = '0;
         coords_d   = '0;
         pt_valid_d = 1'b0;
         pt_index_d = '0;
      end
   end

   // NOTE: the coordinate vector is ordinary flops, not a RAM, so it takes the async reset like everything else.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_dim_q  <= '0;
         coords_q   <= '0;
         pt_valid_q <= 1'b0;
         pt_index_q <= '0;
      end else begin
         col_dim_q  <= col_dim_d;
         coords_q   <= coords_d;
         pt_valid_q <= pt_valid_d;
         pt_index_q <= pt_index_d;
      end
   end

   assign pt_valid  = pt_valid_q;
   assign pt_index  = pt_index_q;
   assign pt_coords = coords_q;
   assign partial   = (col_dim_q != '0);

endmodule

// File: rtl/sobol_point_sequencer.sv
// Issues point-major (idx, dim) requests to the sobol generator and packs responses into points.
// Optional feature macro: SOBOL_SEQ_SKIP_ZERO_EN (base_idx 0 starts issuing at idx 1).
module sobol_point_sequencer
   import sobol_pkg::*;
#(
   parameter int WIDTH           = SOBOL_WIDTH,
   parameter int M               = SOBOL_M,
   parameter int CNT_W           = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [WIDTH-1:0]          base_idx,
   input  logic [CNT_W-1:0]          num_points,
   input  logic [$clog2(M+1)-1:0]    num_dims,
   output logic                      busy,
   output logic                      done,
   output logic                      req_valid,
   input  logic                      req_ready,
   output logic [WIDTH-1:0]          req_idx,
   output logic [$clog2(M)-1:0]      req_dim,
   input  logic                      rsp_valid,
   output logic                      rsp_ready,
   input  logic [WIDTH-1:0]          rsp_data,
   output logic                      pt_valid,
   input  logic                      pt_ready,
   output logic [CNT_W-1:0]          pt_index,
   output logic [M*WIDTH-1:0]        pt_coords
);

   localparam int DIM_W  = $clog2(M);
   localparam int NDIM_W = $clog2(M + 1);
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

   seq_state_e        state_q, state_d;
   logic [WIDTH-1:0]  req_idx_q, req_idx_d;
   logic [DIM_W-1:0]  req_dim_q, req_dim_d;
   logic [NDIM_W-1:0] num_dims_q, num_dims_d;
   logic [CNT_W-1:0]  num_points_q, num_points_d;
   logic [CNT_W-1:0]  pt_cnt_q, pt_cnt_d;
   logic [OUT_W-1:0]  out_q, out_d;

   logic              clear, req_fire, rsp_fire, partial, cfg_ok, last_dim;
   logic [WIDTH-1:0]  first_idx;

`ifdef SOBOL_SEQ_SKIP_ZERO_EN
   assign first_idx = (base_idx == '0) ? WIDTH'(1) : base_idx;
`else
   assign first_idx = base_idx;
`endif

   assign cfg_ok    = (num_points != '0) && (num_dims != '0) && (num_dims <= NDIM_W'(M));
   assign busy      = (state_q == RUN) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign req_valid = (state_q == RUN) && (out_q < OUT_W'(MAX_OUTSTANDING));
   assign req_fire  = req_valid & req_ready;
   assign rsp_fire  = rsp_valid & rsp_ready;
   assign last_dim  = (NDIM_W'(req_dim_q) == num_dims_q - NDIM_W'(1));

   always_comb begin
      state_d      = state_q;
      req_idx_d    = req_idx_q;
      req_dim_d    = req_dim_q;
      num_dims_d   = num_dims_q;
      num_points_d = num_points_q;
      pt_cnt_d     = pt_cnt_q;
      clear        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               num_dims_d   = num_dims;
               num_points_d = num_points;
               req_idx_d    = first_idx;
               req_dim_d    = '0;
               pt_cnt_d     = '0;
               clear        = 1'b1;
               state_d      = cfg_ok ? RUN : DONE;
            end
         end
         RUN: begin
            if (req_fire) begin
               if (last_dim) begin
                  req_dim_d = '0;
                  req_idx_d = req_idx_q + WIDTH'(1);
                  pt_cnt_d  = pt_cnt_q + CNT_W'(1);
                  if (pt_cnt_q == num_points_q - CNT_W'(1)) state_d = DRAIN;
               end else begin
                  req_dim_d = req_dim_q + DIM_W'(1);
               end
            end
         end
         DRAIN: begin
            if ((out_q == '0) && !partial && !pt_valid) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      out_d = out_q;
      case ({req_fire, rsp_fire})
         2'b10:   out_d = out_q + OUT_W'(1);
         2'b01:   out_d = out_q - OUT_W'(1);
         default: out_d = out_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         req_idx_q    <= '0;
         req_dim_q    <= '0;
         num_dims_q   <= '0;
         num_points_q <= '0;
         pt_cnt_q     <= '0;
         out_q        <= '0;
      end else begin
         state_q      <= state_d;
         req_idx_q    <= req_idx_d;
         req_dim_q    <= req_dim_d;
         num_dims_q   <= num_dims_d;
         num_points_q <= num_points_d;
         pt_cnt_q     <= pt_cnt_d;
         out_q        <= out_d;
      end
   end

   assign req_idx = req_idx_q;
   assign req_dim = req_dim_q;

   sobol_point_packer #(
      .WIDTH (WIDTH),
      .M     (M),
      .CNT_W (CNT_W)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .active    (busy),
      .num_dims  (num_dims_q),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .pt_valid  (pt_valid),
      .pt_ready  (pt_ready),
      .pt_index  (pt_index),
      .pt_coords (pt_coords),
      .partial   (partial)
   );

endmodule

// File: tb/tb_sobol_point_sequencer.sv
// Scoreboard bench: a stand-in sobol responder plus request/point queues checked by a monitor.
module tb_sobol_point_sequencer;

   localparam int WIDTH = 32;
   localparam int M     = 50;
   localparam int CNT_W = 16;
   localparam int MAXO  = 4;
   localparam int LAT   = 6;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 start = 1'b0;
   logic [WIDTH-1:0]     base_idx = '0;
   logic [CNT_W-1:0]     num_points = '0;
   logic [5:0]           num_dims = '0;
   logic                 busy, done, req_valid, rsp_ready, pt_valid;
   logic                 req_ready, rsp_valid, pt_ready;
   logic [WIDTH-1:0]     req_idx, rsp_data;
   logic [5:0]           req_dim;
   logic [CNT_W-1:0]     pt_index;
   logic [M*WIDTH-1:0]   pt_coords;

   sobol_point_sequencer #(.WIDTH(WIDTH), .M(M), .CNT_W(CNT_W), .MAX_OUTSTANDING(MAXO)) dut (
      .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .num_points(num_points),
      .num_dims(num_dims), .busy(busy), .done(done), .req_valid(req_valid), .req_ready(req_ready),
      .req_idx(req_idx), .req_dim(req_dim), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_index(pt_index),
      .pt_coords(pt_coords)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] idx; logic [5:0] dim; } req_t;
   typedef struct { logic [15:0] index; logic [31:0] c0; logic [31:0] c1; } pt_t;
   typedef struct { logic [31:0] data; int due; } pend_t;

   req_t  exp_req_q[$];
   pt_t   exp_pt_q[$];
   pend_t pend_q[$];

   int n_checks = 0, n_fail = 0;
   int cyc = 0, done_cnt = 0, req_valid_cycles = 0, total_req = 0;
   int out_cnt = 0, max_out = 0;
   int req_stall = 0, pt_stall = 0;
   logic prev_done = 1'b0, prev_req_stall = 1'b0, prev_pt_stall = 1'b0;
   logic [31:0] held_idx, held_c;
   logic [5:0]  held_dim;
   logic [15:0] held_pi;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Stand-in generator: direction set 0 for dim 0, the x+1 polynomial set otherwise.
   function automatic logic [31:0] sob(input logic [31:0] idx, input logic [5:0] dim);
      logic [31:0] g, v, acc;
      g = idx ^ (idx >> 1);
      v = 32'h8000_0000;
      acc = '0;
      for (int k = 0; k < 32; k++) begin
         if (g[k]) acc ^= v;
         v = (dim == 6'd0) ? (v >> 1) : (v ^ (v >> 1));
      end
      return acc;
   endfunction

   function automatic logic [31:0] fidx(input logic [31:0] base);
`ifdef SOBOL_SEQ_SKIP_ZERO_EN
      return (base == 32'd0) ? 32'd1 : base;
`else
      return base;
`endif
   endfunction

   task automatic push_req(input logic [31:0] idx, input logic [5:0] dim);
      req_t r;
      r.idx = idx; r.dim = dim;
      exp_req_q.push_back(r);
   endtask

   task automatic push_pt(input logic [15:0] index, input logic [31:0] c0, input logic [31:0] c1);
      pt_t p;
      p.index = index; p.c0 = c0; p.c1 = c1;
      exp_pt_q.push_back(p);
   endtask

   task automatic push_run(input logic [31:0] base, input int np, input int nd);
      logic [31:0] idx;
      for (int p = 0; p < np; p++) begin
         idx = fidx(base) + 32'(p);
         for (int d = 0; d < nd; d++) push_req(idx, 6'(d));
         push_pt(16'(p), sob(idx, 6'd0), (nd > 1) ? sob(idx, 6'd1) : 32'd0);
      end
   endtask

   // Responder and monitor: inputs change on the falling edge, transfers are judged 1ns later.
   initial begin
      logic rf, sf, pf;
      pt_t  ep;
      req_t er;
      pend_t pe;
      req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; pt_ready = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         req_ready = (req_stall == 0);
         if (req_stall > 0) req_stall--;
         pt_ready = (pt_stall == 0);
         if (pt_stall > 0) pt_stall--;
         if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            rsp_valid = 1'b1; rsp_data = pend_q[0].data;
         end else begin
            rsp_valid = 1'b0; rsp_data = '0;
         end
         #1;
         if (!rst) begin
            rf = req_valid & req_ready;
            sf = rsp_valid & rsp_ready;
            pf = pt_valid & pt_ready;
            if (req_valid) req_valid_cycles++;
            if (done) begin
               done_cnt++;
               check("done_single_cycle", 64'(prev_done), 64'd0);
            end
            prev_done = done;
            if (prev_req_stall) begin
               check("req_held_valid", 64'(req_valid), 64'd1);
               check("req_held_idx_dim", {26'd0, held_dim, held_idx} ^ {26'd0, req_dim, req_idx}, 64'd0);
            end
            if (prev_pt_stall) begin
               check("pt_held_valid", 64'(pt_valid), 64'd1);
               check("pt_held_data", {16'd0, pt_index, pt_coords[31:0]}, {16'd0, held_pi, held_c});
            end
            if (pt_valid && !pt_ready) check("rsp_ready_blocked", 64'(rsp_ready), 64'd0);
            prev_req_stall = req_valid & ~req_ready;
            held_idx = req_idx; held_dim = req_dim;
            prev_pt_stall = pt_valid & ~pt_ready;
            held_pi = pt_index; held_c = pt_coords[31:0];
            if (rf) begin
               check("req_expected", 64'(exp_req_q.size() > 0), 64'd1);
               if (exp_req_q.size() > 0) begin
                  er = exp_req_q.pop_front();
                  check("req_idx_dim", {26'd0, req_dim, req_idx}, {26'd0, er.dim, er.idx});
               end
               pe.data = sob(req_idx, req_dim);
               pe.due  = cyc + LAT;
               pend_q.push_back(pe);
               total_req++;
            end
            if (sf && pend_q.size() > 0) void'(pend_q.pop_front());
            if (pf) begin
               check("pt_expected", 64'(exp_pt_q.size() > 0), 64'd1);
               if (exp_pt_q.size() > 0) begin
                  ep = exp_pt_q.pop_front();
                  check("pt_index", 64'(pt_index), 64'(ep.index));
                  check("pt_coords_lo", pt_coords[63:0], {ep.c1, ep.c0});
                  check("pt_coords_hi_zero", 64'(|pt_coords[M*WIDTH-1:64]), 64'd0);
               end
            end
            out_cnt = out_cnt + int'(rf) - int'(sf);
            if (out_cnt > max_out) max_out = out_cnt;
         end
      end
   end

   task automatic run(input logic [31:0] base, input logic [15:0] np, input logic [5:0] nd,
                      input string name);
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      base_idx = base; num_points = np; num_dims = nd; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 400 && done_cnt == d0; c++) @(negedge clk);
      repeat (3) @(negedge clk);
      check({name, "_done_count"}, 64'(done_cnt - d0), 64'd1);
      check({name, "_reqs_drained"}, 64'(exp_req_q.size()), 64'd0);
      check({name, "_pts_drained"}, 64'(exp_pt_q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_ctrl"}, {59'd0, busy, done, req_valid, rsp_ready, pt_valid}, 64'd0);
      check({name, "_req_idx_dim"}, {26'd0, req_dim, req_idx}, 64'd0);
      check({name, "_pt_index"}, 64'(pt_index), 64'd0);
      check({name, "_pt_coords"}, 64'(|pt_coords), 64'd0);
   endtask

   task automatic degenerate(input logic [15:0] np, input logic [5:0] nd, input string name);
      int rv0;
      rv0 = req_valid_cycles;
      @(negedge clk);
      num_points = np; num_dims = nd; base_idx = 32'd7; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #2 check({name, "_done_next_cycle"}, 64'(done), 64'd1);
      @(negedge clk);
      #2 check({name, "_done_drops"}, 64'(done), 64'd0);
      check({name, "_no_req_valid"}, 64'(req_valid_cycles - rv0), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      #3 check_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Basic run, sobol always ready.
`ifdef SOBOL_SEQ_SKIP_ZERO_EN
      push_req(32'd1, 6'd0); push_req(32'd2, 6'd0);
      push_pt(16'd0, 32'h8000_0000, 32'd0);
      push_pt(16'd1, 32'hC000_0000, 32'd0);
      run(32'd0, 16'd2, 6'd1, "skip_zero");
`else
      push_req(32'd0, 6'd0); push_req(32'd0, 6'd1);
      push_req(32'd1, 6'd0); push_req(32'd1, 6'd1);
      push_pt(16'd0, 32'h0000_0000, 32'h0000_0000);
      push_pt(16'd1, 32'h8000_0000, 32'h8000_0000);
      run(32'd0, 16'd2, 6'd2, "basic");
`endif

      // Request stall plus an ignored start mid-run.
      for (int p = 4; p < 7; p++) begin
         push_req(32'(p), 6'd0); push_req(32'(p), 6'd1);
      end
      push_pt(16'd0, 32'h6000_0000, 32'h6000_0000);
      push_pt(16'd1, 32'hE000_0000, 32'hE000_0000);
      push_pt(16'd2, 32'hA000_0000, 32'h2000_0000);
      fork
         run(32'd4, 16'd3, 6'd2, "req_stall");
         begin
            repeat (3) @(posedge clk);
            req_stall = 3;
            @(negedge clk);
            base_idx = 32'd99; num_points = 16'd9; num_dims = 6'd3; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join

      // Downstream stall of five cycles.
      push_req(32'd1, 6'd0); push_req(32'd1, 6'd1);
      push_req(32'd2, 6'd0); push_req(32'd2, 6'd1);
      push_req(32'd3, 6'd0); push_req(32'd3, 6'd1);
      push_pt(16'd0, 32'h8000_0000, 32'h8000_0000);
      push_pt(16'd1, 32'hC000_0000, 32'h4000_0000);
      push_pt(16'd2, 32'h4000_0000, 32'hC000_0000);
      fork
         run(32'd1, 16'd3, 6'd2, "pt_stall");
         begin
            for (int c = 0; c < 200 && !pt_valid; c++) @(negedge clk);
            @(posedge clk);
            pt_stall = 5;
         end
      join

      // Index wrap.
      push_req(32'hFFFF_FFFF, 6'd0); push_req(32'h0000_0000, 6'd0);
      push_pt(16'd0, 32'h0000_0001, 32'd0);
      push_pt(16'd1, 32'h0000_0000, 32'd0);
      run(32'hFFFF_FFFF, 16'd2, 6'd1, "wrap");

      degenerate(16'd0, 6'd2, "zero_points");
      degenerate(16'd2, 6'd0, "zero_dims");
      degenerate(16'd1, 6'd51, "too_many_dims");

      // Reset during DRAIN, then a clean rerun.
      push_req(fidx(32'd0), 6'd0); push_req(fidx(32'd0), 6'd1);
      @(negedge clk);
      base_idx = 32'd0; num_points = 16'd1; num_dims = 6'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int t0;
         t0 = total_req;
         for (int c = 0; c < 100 && total_req < t0 + 2; c++) @(negedge clk);
      end
      #2 check("drain_busy_no_req", {62'd0, busy, req_valid}, 64'd2);
      @(negedge clk);
      rst = 1'b1;
      #1 check_reset_outputs("rst_in_drain");
      pend_q.delete(); exp_req_q.delete(); exp_pt_q.delete();
      out_cnt = 0; prev_done = 1'b0; prev_req_stall = 1'b0; prev_pt_stall = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      push_run(32'd0, 2, 2);
      run(32'd0, 16'd2, 6'd2, "after_reset");

      check("max_outstanding_reached", 64'(max_out), 64'(MAXO));
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
